// File: rtl/lock_sequencer_pkg.sv
// Shared constants for the lock sequencer and the code checker: state encodings,
// keypad codes, checker compare types and the per-state control decode.
package lock_sequencer_pkg;

    typedef enum logic [3:0] {
        S_LOCKED      = 4'd0,
        S_CHECK_UC    = 4'd1,
        S_UNLOCKED    = 4'd2,
        S_NEW_UC      = 4'd3,
        S_CONFIRM_UC  = 4'd4,
        S_CHECK_MATCH = 4'd5,
        S_COMMIT      = 4'd6,
        S_LOCKOUT     = 4'd7,
        S_CHECK_PC    = 4'd8
    } state_t;

    localparam logic [3:0] KEY_CLEAR = 4'd7;
    localparam logic [3:0] KEY_ENTER = 4'd8;
    localparam logic [3:0] KEY_PROG  = 4'd9;

    localparam logic [1:0] CT_COMPAREPC = 2'b00;
    localparam logic [1:0] CT_COMPAREUC = 2'b01;
    localparam logic [1:0] CT_MATCHUC   = 2'b10;
    localparam logic [1:0] CT_STOREUC   = 2'b11;

    typedef struct packed {
        logic [1:0] compare_type;
        logic       read_input;
        logic       store;
        logic       unlocked;
        logic       lockout;
    } ctrl_t;

    // Checker controls and indicators that hold for the whole time spent in a state.
    function automatic ctrl_t decode_ctrl(state_t s);
        ctrl_t c;
        c = '{compare_type: CT_COMPAREUC, read_input: 1'b0, store: 1'b0,
              unlocked: 1'b0, lockout: 1'b0};
        case (s)
            S_LOCKED:      c.read_input = 1'b1;
            S_CHECK_UC:    c.compare_type = CT_COMPAREUC;
            S_UNLOCKED:    c.unlocked = 1'b1;
            S_NEW_UC:      begin c.compare_type = CT_STOREUC; c.read_input = 1'b1; c.unlocked = 1'b1; end
            S_CONFIRM_UC:  begin c.compare_type = CT_MATCHUC; c.read_input = 1'b1; c.unlocked = 1'b1; end
            S_CHECK_MATCH: begin c.compare_type = CT_MATCHUC; c.unlocked = 1'b1; end
            S_COMMIT:      begin c.compare_type = CT_STOREUC; c.store = 1'b1; c.unlocked = 1'b1; end
            S_LOCKOUT:     begin c.compare_type = CT_COMPAREPC; c.read_input = 1'b1; c.lockout = 1'b1; end
            S_CHECK_PC:    begin c.compare_type = CT_COMPAREPC; c.lockout = 1'b1; end
            default:       c.read_input = 1'b1;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Saturating cycle counter with synchronous clear; done flags the last cycle of a
// LIMIT-cycle interval so the owner can leave on that edge.
module lock_timer #(
    parameter int unsigned LIMIT = 8
) (
    input  logic hwclk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic done
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] count_q, count_d;

    assign done = en && (count_q == W'(LIMIT - 1));

    always_comb begin
        count_d = count_q;
        if (clear)
            count_d = '0;
        else if (en && !done)
            count_d = count_q + W'(1);
    end

    always_ff @(posedge hwclk) begin
        if (reset)
            count_q <= '0;
        else
            count_q <= count_d;
    end

endmodule

// File: rtl/lock_sequencer.sv
// Digital lock sequencer: drives the code checker, runs unlock, user-code change,
// retry counting, lockout and master-code recovery. All outputs are registered.
module lock_sequencer #(
    parameter int unsigned MAX_TRIES      = 3,
    parameter int unsigned VERDICT_CYCLES = 1200,
    parameter int unsigned UNLOCK_CYCLES  = 60000000,
    parameter int unsigned LOCKOUT_CYCLES = 120000000,
    parameter int unsigned STORE_CYCLES   = 4
) (
    input  logic       hwclk,
    input  logic       reset,
    input  logic       btn_press,
    input  logic [3:0] button,
    input  logic       dataready,
    input  logic       correct,
    output logic [1:0] compare_type,
    output logic       read_input,
    output logic       store,
    output logic       unlocked,
    output logic       lockout,
    output logic       input_wrong,
    output logic [3:0] state_dbg
);

    import lock_sequencer_pkg::*;

    localparam int TW = $clog2(MAX_TRIES + 1);

    state_t        state_q, state_d;
    logic [TW-1:0] tries_q, tries_d;
    logic          wrong_q, wrong_d;
    ctrl_t         ctrl_q, ctrl_d;

    logic key_enter, key_prog, verdict_ok, in_check, entry, idle_kick;
    logic verdict_done, idle_done, lockout_done, store_done;

    assign key_enter  = btn_press && (button == KEY_ENTER);
    assign key_prog   = btn_press && (button == KEY_PROG);
    assign verdict_ok = dataready && correct;
    assign in_check   = (state_q == S_CHECK_UC) || (state_q == S_CHECK_MATCH) || (state_q == S_CHECK_PC);
    assign entry      = (state_d != state_q);
    assign idle_kick  = (state_q == S_UNLOCKED) && btn_press;

    // One verdict timer serves all three CHECK_* states; entry clears it.
    lock_timer #(.LIMIT(VERDICT_CYCLES)) u_verdict_timer (
        .hwclk(hwclk), .reset(reset), .clear(entry),
        .en(in_check), .done(verdict_done));

    lock_timer #(.LIMIT(UNLOCK_CYCLES)) u_idle_timer (
        .hwclk(hwclk), .reset(reset), .clear(entry || idle_kick),
        .en(state_q == S_UNLOCKED), .done(idle_done));

    lock_timer #(.LIMIT(LOCKOUT_CYCLES)) u_lockout_timer (
        .hwclk(hwclk), .reset(reset), .clear(entry),
        .en(state_q == S_LOCKOUT), .done(lockout_done));

    lock_timer #(.LIMIT(STORE_CYCLES)) u_store_timer (
        .hwclk(hwclk), .reset(reset), .clear(entry),
        .en(state_q == S_COMMIT), .done(store_done));

    always_ff @(posedge hwclk) begin
        if (reset) begin
            state_q <= S_LOCKED;
            tries_q <= '0;
            wrong_q <= 1'b0;
            ctrl_q  <= decode_ctrl(S_LOCKED);
        end else begin
            state_q <= state_d;
            tries_q <= tries_d;
            wrong_q <= wrong_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // A verdict is tested before the timeout, so a success on the last cycle wins.
    always_comb begin
        state_d = state_q;
        tries_d = tries_q;
        wrong_d = 1'b0;
        case (state_q)
            S_LOCKED:
                if (key_enter) state_d = S_CHECK_UC;
            S_CHECK_UC:
                if (verdict_ok) begin
                    state_d = S_UNLOCKED;
                    tries_d = '0;
                end else if (verdict_done) begin
                    wrong_d = 1'b1;
                    if (tries_q >= TW'(MAX_TRIES - 1)) begin
                        state_d = S_LOCKOUT;
                        tries_d = TW'(MAX_TRIES);
                    end else begin
                        state_d = S_LOCKED;
                        tries_d = tries_q + TW'(1);
                    end
                end
            S_UNLOCKED:
                if (key_prog)
                    state_d = S_NEW_UC;
                else if (!btn_press && idle_done)
                    state_d = S_LOCKED;
            S_NEW_UC:
                if (key_enter) state_d = S_CONFIRM_UC;
            S_CONFIRM_UC:
                if (key_enter) state_d = S_CHECK_MATCH;
            S_CHECK_MATCH:
                if (verdict_ok) begin
                    state_d = S_COMMIT;
                end else if (verdict_done) begin
                    wrong_d = 1'b1;
                    state_d = S_UNLOCKED;
                end
            S_COMMIT:
                if (store_done) state_d = S_LOCKED;
            S_LOCKOUT:
                if (lockout_done) begin
                    state_d = S_LOCKED;
                    tries_d = '0;
                end else if (key_enter) begin
                    state_d = S_CHECK_PC;
                end
            S_CHECK_PC:
                if (verdict_ok) begin
                    state_d = S_LOCKED;
                    tries_d = '0;
                end else if (verdict_done) begin
                    wrong_d = 1'b1;
                    state_d = S_LOCKOUT;
                end
            default:
                state_d = S_LOCKED;
        endcase
    end

    always_comb begin
        ctrl_d = decode_ctrl(state_d);
    end

    assign compare_type = ctrl_q.compare_type;
    assign read_input   = ctrl_q.read_input;
    assign store        = ctrl_q.store;
    assign unlocked     = ctrl_q.unlocked;
    assign lockout      = ctrl_q.lockout;
    assign input_wrong  = wrong_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_lock_sequencer.sv
// Self-checking bench for lock_sequencer: directed vector table, hand sequences
// for timing corners, then random stimulus against a cycle-age reference model.
module tb_lock_sequencer;
    import lock_sequencer_pkg::*;

    localparam int MT = 3, VC = 8, UC = 50, LC = 40, SC = 4;

    logic       hwclk = 1'b0;
    logic       reset = 1'b1, btn_press = 1'b0, dataready = 1'b0, correct = 1'b0;
    logic [3:0] button = 4'd0;
    logic [1:0] compare_type;
    logic       read_input, store, unlocked, lockout, input_wrong;
    logic [3:0] state_dbg;

    lock_sequencer #(.MAX_TRIES(MT), .VERDICT_CYCLES(VC), .UNLOCK_CYCLES(UC),
                     .LOCKOUT_CYCLES(LC), .STORE_CYCLES(SC)) dut (
        .hwclk(hwclk), .reset(reset), .btn_press(btn_press), .button(button),
        .dataready(dataready), .correct(correct), .compare_type(compare_type),
        .read_input(read_input), .store(store), .unlocked(unlocked),
        .lockout(lockout), .input_wrong(input_wrong), .state_dbg(state_dbg));

    always #5 hwclk = ~hwclk;

    int n_cmp = 0, n_bad = 0;

    // Reference model: state name, cycles spent in it, failed-try count.
    state_t m_st = S_LOCKED;
    int     m_age = 0, m_tries = 0;
    bit     m_wrong = 1'b0;

    // Per-state expected outputs, indexed by state code.
    logic [1:0] ct_t [9] = '{2'b01, 2'b01, 2'b01, 2'b11, 2'b10, 2'b10, 2'b11, 2'b00, 2'b00};
    bit         ri_t [9] = '{1, 0, 0, 1, 1, 0, 0, 1, 0};
    bit         st_t [9] = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
    bit         un_t [9] = '{0, 0, 1, 1, 1, 1, 1, 0, 0};
    bit         lo_t [9] = '{0, 0, 0, 0, 0, 0, 0, 1, 1};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit rst, input bit bp, input logic [3:0] key,
                              input bit dr, input bit cor);
        state_t nxt;
        bit ok, kick, expired;
        int limit;
        nxt = m_st; ok = dr && cor; kick = 0; m_wrong = 0;
        if (rst) begin
            m_st = S_LOCKED; m_age = 0; m_tries = 0;
            return;
        end
        case (m_st)
            S_CHECK_UC, S_CHECK_MATCH, S_CHECK_PC: limit = VC;
            S_UNLOCKED: limit = UC;
            S_LOCKOUT:  limit = LC;
            S_COMMIT:   limit = SC;
            default:    limit = 0;
        endcase
        expired = (limit != 0) && (m_age + 1 >= limit);
        case (m_st)
            S_LOCKED:     if (bp && key == KEY_ENTER) nxt = S_CHECK_UC;
            S_NEW_UC:     if (bp && key == KEY_ENTER) nxt = S_CONFIRM_UC;
            S_CONFIRM_UC: if (bp && key == KEY_ENTER) nxt = S_CHECK_MATCH;
            S_CHECK_UC:
                if (ok) begin nxt = S_UNLOCKED; m_tries = 0; end
                else if (expired) begin
                    m_wrong = 1;
                    m_tries = (m_tries + 1 > MT) ? MT : m_tries + 1;
                    nxt = (m_tries >= MT) ? S_LOCKOUT : S_LOCKED;
                end
            S_UNLOCKED:
                if (bp) begin
                    if (key == KEY_PROG) nxt = S_NEW_UC; else kick = 1;
                end else if (expired) nxt = S_LOCKED;
            S_CHECK_MATCH:
                if (ok) nxt = S_COMMIT;
                else if (expired) begin m_wrong = 1; nxt = S_UNLOCKED; end
            S_COMMIT: if (expired) nxt = S_LOCKED;
            S_LOCKOUT:
                if (expired) begin nxt = S_LOCKED; m_tries = 0; end
                else if (bp && key == KEY_ENTER) nxt = S_CHECK_PC;
            S_CHECK_PC:
                if (ok) begin nxt = S_LOCKED; m_tries = 0; end
                else if (expired) begin m_wrong = 1; nxt = S_LOCKOUT; end
            default: nxt = S_LOCKED;
        endcase
        if (nxt != m_st || kick) m_age = 0; else m_age++;
        m_st = nxt;
    endtask

    function automatic logic [10:0] dut_out();
        return {state_dbg, compare_type, read_input, store, unlocked, lockout, input_wrong};
    endfunction

    // One clock: drive inputs, step the model on the edge, compare just after it.
    task automatic tick(input bit rst, input bit bp, input logic [3:0] key,
                        input bit dr, input bit cor);
        int s;
        reset = rst; btn_press = bp; button = key; dataready = dr; correct = cor;
        @(posedge hwclk);
        model_step(rst, bp, key, dr, cor);
        #1;
        s = int'(m_st);
        check("model", {21'd0, dut_out()},
              {21'd0, 4'(s), ct_t[s], ri_t[s], st_t[s], un_t[s], lo_t[s], m_wrong});
    endtask

    task automatic idle(input int n);
        repeat (n) tick(0, 0, 4'd0, 0, 0);
    endtask
    task automatic press(input logic [3:0] k);
        tick(0, 1, k, 0, 0);
    endtask
    task automatic verdict();
        tick(0, 0, 4'd0, 1, 1);
    endtask
    task automatic fail_try();
        press(KEY_ENTER);
        idle(VC - 1);
        check("still_checking", state_dbg, 4'd1);
        idle(1);
        check("wrong_pulse", input_wrong, 1'b1);
    endtask

    typedef struct {
        bit rst, bp; logic [3:0] key; bit dr, cor;
        logic [3:0] st; logic [1:0] ct; bit ri, stor, unl, lo, wr;
    } vec_t;
    vec_t tbl [15];

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] k;
        tbl[0]  = '{1, 0, 4'd0,      0, 0, 4'd0, 2'b01, 1, 0, 0, 0, 0};
        tbl[1]  = '{0, 1, KEY_ENTER, 0, 0, 4'd1, 2'b01, 0, 0, 0, 0, 0};
        tbl[2]  = '{0, 0, 4'd0,      0, 0, 4'd1, 2'b01, 0, 0, 0, 0, 0};
        tbl[3]  = '{0, 0, 4'd0,      1, 1, 4'd2, 2'b01, 0, 0, 1, 0, 0};
        tbl[4]  = '{0, 1, KEY_PROG,  0, 0, 4'd3, 2'b11, 1, 0, 1, 0, 0};
        tbl[5]  = '{0, 1, KEY_ENTER, 0, 0, 4'd4, 2'b10, 1, 0, 1, 0, 0};
        tbl[6]  = '{0, 1, KEY_ENTER, 0, 0, 4'd5, 2'b10, 0, 0, 1, 0, 0};
        tbl[7]  = '{0, 1, KEY_ENTER, 0, 0, 4'd5, 2'b10, 0, 0, 1, 0, 0};
        tbl[8]  = '{0, 0, 4'd0,      1, 1, 4'd6, 2'b11, 0, 1, 1, 0, 0};
        tbl[9]  = '{0, 0, 4'd0,      0, 0, 4'd6, 2'b11, 0, 1, 1, 0, 0};
        tbl[10] = '{0, 0, 4'd0,      0, 0, 4'd6, 2'b11, 0, 1, 1, 0, 0};
        tbl[11] = '{0, 0, 4'd0,      0, 0, 4'd6, 2'b11, 0, 1, 1, 0, 0};
        tbl[12] = '{0, 0, 4'd0,      0, 0, 4'd0, 2'b01, 1, 0, 0, 0, 0};
        tbl[13] = '{0, 0, 4'd0,      1, 1, 4'd0, 2'b01, 1, 0, 0, 0, 0};
        tbl[14] = '{0, 1, KEY_CLEAR, 0, 0, 4'd0, 2'b01, 1, 0, 0, 0, 0};

        foreach (tbl[i]) begin
            tick(tbl[i].rst, tbl[i].bp, tbl[i].key, tbl[i].dr, tbl[i].cor);
            check($sformatf("vec%0d", i), {21'd0, dut_out()},
                  {21'd0, tbl[i].st, tbl[i].ct, tbl[i].ri, tbl[i].stor,
                   tbl[i].unl, tbl[i].lo, tbl[i].wr});
        end

        // Three timeouts -> lockout, which expires after LC cycles.
        fail_try(); check("try1_locked", state_dbg, 4'd0);
        fail_try(); check("try2_locked", state_dbg, 4'd0);
        fail_try(); check("try3_lockout", lockout, 1'b1);
        idle(LC - 1); check("lockout_held", lockout, 1'b1);
        idle(1);      check("lockout_expired", {lockout, state_dbg}, {1'b0, 4'd0});
        fail_try();   check("tries_cleared", state_dbg, 4'd0);

        // Idle relock; a key on the last idle cycle restarts the timer.
        press(KEY_ENTER); verdict();
        check("unlock", unlocked, 1'b1);
        idle(UC - 1);  check("idle_49", unlocked, 1'b1);
        press(4'd5);   check("kick_at_49", unlocked, 1'b1);
        idle(UC - 1);  check("idle_after_kick", state_dbg, 4'd2);
        idle(1);       check("relock", {unlocked, state_dbg}, {1'b0, 4'd0});

        // Master-code recovery, then a wrong master code restarting the lockout timer.
        fail_try(); fail_try(); fail_try();
        press(KEY_ENTER); check("check_pc", {state_dbg, compare_type, lockout}, {4'd8, 2'b00, 1'b1});
        idle(2); verdict();
        check("pc_ok", {lockout, state_dbg}, {1'b0, 4'd0});
        fail_try(); check("pc_cleared_tries", state_dbg, 4'd0);
        fail_try(); fail_try(); check("relockout", state_dbg, 4'd7);
        idle(30);
        press(KEY_ENTER); idle(VC);
        check("pc_wrong", {state_dbg, lockout}, {4'd7, 1'b1});
        idle(LC - 1); check("lockout_restarted", lockout, 1'b1);
        idle(1);      check("lockout_done2", state_dbg, 4'd0);

        // Verdict on the timeout cycle wins.
        press(KEY_ENTER); idle(VC - 1); verdict();
        check("verdict_wins", {state_dbg, input_wrong}, {4'd2, 1'b0});

        // Match timeout returns to UNLOCKED without locking.
        press(KEY_PROG); press(KEY_ENTER); press(KEY_ENTER); idle(VC);
        check("match_timeout", {state_dbg, unlocked, input_wrong}, {4'd2, 1'b1, 1'b1});

        // Reset in the middle of COMMIT.
        press(KEY_PROG); press(KEY_ENTER); press(KEY_ENTER); verdict();
        check("commit_store", store, 1'b1);
        idle(1);
        tick(1, 0, 4'd0, 0, 0);
        check("reset_commit", {store, state_dbg}, {1'b0, 4'd0});

        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 9);
            k = (r < 4) ? KEY_ENTER : (r == 4) ? KEY_PROG : 4'($urandom_range(0, 15));
            tick($urandom_range(0, 599) == 0, $urandom_range(0, 99) < 30, k,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
